rst_seq: RTL

RST_SEQ -- requirements
Module: rst_seq

---
 rtl/rst_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rst_seq.sv
// Reset sequencer: waits for a stable clock-source lock, releases the divider reset, then the system reset.
// Optional lock-loss counter output loss_cnt is built when RST_SEQ_LOSSCNT_EN is defined.
module rst_seq #(
  parameter int STABLE_CYC  = 16,
  parameter int SYS_DLY_CYC = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       lock_in,
  input  logic       sw_rst_req,
  output logic       div_rstn,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state_o
`ifdef RST_SEQ_LOSSCNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  // state     | meaning
  // WAIT_LOCK | holding all resets, waiting for synchronized lock
  // STABLE    | lock seen, counting STABLE_CYC lock-high edges
  // DIV_REL   | divider running, counting SYS_DLY_CYC edges
  // READY     | sequence complete, system out of reset
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    DIV_REL   = 3'd2,
    READY     = 3'd3
  } state_t;

  localparam int MAX_CYC = (STABLE_CYC > SYS_DLY_CYC) ? STABLE_CYC : SYS_DLY_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] STABLE_TC = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] DLY_TC    = CW'(SYS_DLY_CYC - 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], lock_in};
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_TC) begin
          state_nxt = DIV_REL;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DIV_REL: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == DLY_TC) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      READY: begin
        // lock loss wins over a same-cycle software request
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (sw_rst_req) begin
          state_nxt = DIV_REL;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      div_rstn <= 1'b0;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      div_rstn <= (state_nxt == DIV_REL) || (state_nxt == READY);
      sys_rst  <= (state_nxt != READY);
      ready    <= (state_nxt == READY);
    end
  end

  assign state_o = state;

`ifdef RST_SEQ_LOSSCNT_EN
  logic loss;
  assign loss = !lock_s && ((state == STABLE) || (state == DIV_REL) || (state == READY));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)                            loss_cnt <= 8'd0;
    else if (loss && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end
`else
  // loss counter not built
`endif

endmodule
